// File: rtl/rv_uart_tx.sv
// rv_uart_tx: FIFO-buffered UART transmitter (8 data bits, LSB first, 1 stop bit).
// Define RV_UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module rv_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef RV_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_overflow;

   state_t      r_state;
   logic [15:0] r_baud;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic        r_tx;
   logic        r_busy;
`ifdef RV_UART_TX_PARITY_EN
   logic        r_parity;
`endif

   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   logic       w_baud_done;
   logic [7:0] w_head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_push      = in_valid && !w_full;
   assign w_baud_done = (r_baud == BAUD_LAST);
   assign w_pop       = !w_empty &&
                        ((r_state == S_IDLE) || (r_state == S_STOP && w_baud_done));
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

   assign in_ready   = !w_full;
   assign fifo_count = r_wr_ptr - r_rd_ptr;
   assign overflow   = r_overflow;
   assign tx         = r_tx;
   assign busy       = r_busy;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (in_valid && w_full) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
`ifdef RV_UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift  <= w_head;
                  r_baud   <= '0;
                  r_state  <= S_START;
                  r_tx     <= 1'b0;
                  r_busy   <= 1'b1;
`ifdef RV_UART_TX_PARITY_EN
                  r_parity <= ^w_head;
`endif
               end
            end
            S_START: begin
               if (w_baud_done) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
`ifdef RV_UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_parity;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
`ifdef RV_UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  // Chain straight into the next start bit so frames stay contiguous.
                  if (w_pop) begin
                     r_shift  <= w_head;
                     r_state  <= S_START;
                     r_tx     <= 1'b0;
`ifdef RV_UART_TX_PARITY_EN
                     r_parity <= ^w_head;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rv_uart_tx.sv
// Directed bench for rv_uart_tx: instance a (CLKS_PER_BIT=4, DEPTH=16), instance b (CLKS_PER_BIT=16, DEPTH=4).
module tb_rv_uart_tx;
`ifdef RV_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 1'b0;
   logic [7:0] a_data = 8'h00;
   logic       a_ready, a_tx, a_busy, a_ovf;
   logic [4:0] a_count;
   logic       b_valid = 1'b0;
   logic [7:0] b_data = 8'h00;
   logic       b_ready, b_tx, b_busy, b_ovf;
   logic [2:0] b_count;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rv_uart_tx #(.CLKS_PER_BIT(4), .DEPTH(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
      .tx(a_tx), .busy(a_busy), .fifo_count(a_count), .overflow(a_ovf)
   );

   rv_uart_tx #(.CLKS_PER_BIT(16), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
      .tx(b_tx), .busy(b_busy), .fifo_count(b_count), .overflow(b_ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected line level at bit position pos of a frame carrying byte b.
   function automatic logic exp_bit(input logic [7:0] b, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
`ifdef RV_UART_TX_PARITY_EN
      if (pos == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", a_tx); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
      total++; if (a_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", a_count); end
      total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", a_ovf); end
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
      total++; if (b_tx !== 1'b1) begin bad++; $display("FAIL reset_b_tx got=%b want=1", b_tx); end
      total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b want=1", b_ready); end
      $display("reset: released, checks done");
   endtask

   task automatic test_single();
      a_valid = 1'b1;
      a_data  = 8'h55;
      step();
      a_valid = 1'b0;
      total++; if (a_count !== 5'd1) begin bad++; $display("FAIL single_count_push got=%0d want=1", a_count); end
      total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL single_tx_before got=%b want=1", a_tx); end
      for (int i = 0; i < NB*4; i++) begin
         step();
         if (i == 0) begin
            total++; if (a_count !== 5'd0) begin bad++; $display("FAIL single_count_pop got=%0d want=0", a_count); end
         end
         total++; if (a_tx !== exp_bit(8'h55, i/4)) begin bad++; $display("FAIL single_tx cyc=%0d got=%b want=%b", i, a_tx, exp_bit(8'h55, i/4)); end
         total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=1", i, a_busy); end
      end
      step();
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b want=0", a_busy); end
      total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL single_tx_idle got=%b want=1", a_tx); end
      $display("single: byte 0x55 frame of %0d cycles checked", NB*4);
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      a_valid = 1'b1;
      a_data  = 8'hA5;
      step();
      for (int i = 0; i < 2*NB*4; i++) begin
         if (i == 0) a_data = 8'h3C;
         step();
         if (i == 0) begin
            a_valid = 1'b0;
            total++; if (a_count !== 5'd1) begin bad++; $display("FAIL b2b_count got=%0d want=1", a_count); end
         end
         b = (i < NB*4) ? 8'hA5 : 8'h3C;
         total++; if (a_tx !== exp_bit(b, (i % (NB*4))/4)) begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b want=%b", i, a_tx, exp_bit(b, (i % (NB*4))/4)); end
         total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b want=1", i, a_busy); end
      end
      step();
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_fall got=%b want=0", a_busy); end
      $display("back_to_back: 0xA5,0x3C over %0d cycles checked", 2*NB*4);
   endtask

   task automatic test_overflow();
      int fl;
      int last;
      int i;
      logic [7:0] b;
      fl = NB*16;
      last = 5*fl;
      for (int c = 0; c <= last + 20; c++) begin
         if (c < 6) begin
            b_valid = 1'b1;
            b_data  = 8'((c+1)*17);
         end else begin
            b_valid = 1'b0;
         end
         step();
         if (c == 4) begin
            total++; if (b_count !== 3'd4) begin bad++; $display("FAIL ovf_count_full got=%0d want=4", b_count); end
            total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b want=0", b_ready); end
            total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", b_ovf); end
         end
         if (c == 5) begin
            total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", b_ovf); end
            total++; if (b_count !== 3'd4) begin bad++; $display("FAIL ovf_count_drop got=%0d want=4", b_count); end
         end
         if (c >= 1 && c <= last) begin
            i = c - 1;
            b = 8'(((i / fl) + 1)*17);
            total++; if (b_tx !== exp_bit(b, (i % fl)/16)) begin bad++; $display("FAIL ovf_tx cyc=%0d got=%b want=%b", i, b_tx, exp_bit(b, (i % fl)/16)); end
            total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL ovf_busy cyc=%0d got=%b want=1", i, b_busy); end
         end
         if (c == last + 1) begin
            total++; if (b_count !== 3'd0) begin bad++; $display("FAIL ovf_count_end got=%0d want=0", b_count); end
         end
         if (c > last) begin
            total++; if (b_busy !== 1'b0 || b_tx !== 1'b1) begin bad++; $display("FAIL ovf_no_sixth cyc=%0d busy=%b tx=%b want busy=0 tx=1", c, b_busy, b_tx); end
         end
      end
      $display("overflow: 6 pushes, 5 frames checked, overflow=%b", b_ovf);
   endtask

   task automatic test_reset_mid_operation();
      a_valid = 1'b1;
      a_data  = 8'h12;
      step();
      a_data  = 8'h34;
      step();
      a_valid = 1'b0;
      step();
      rst = 1'b1;
      repeat (3) step();
      total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL rstop_tx got=%b want=1", a_tx); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rstop_busy got=%b want=0", a_busy); end
      total++; if (a_count !== 5'd0) begin bad++; $display("FAIL rstop_count got=%0d want=0", a_count); end
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rstop_ready got=%b want=1", a_ready); end
      total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL rstop_overflow got=%b want=0", b_ovf); end
      rst = 1'b0;
      step();
      $display("reset_mid_operation: 3-cycle reset checked");
   endtask

   task automatic test_reset_mid_frame();
      a_valid = 1'b1;
      a_data  = 8'hFF;
      step();
      a_data  = 8'h81;
      step();
      a_valid = 1'b0;
      // Now after edge N+1; data bit 3 spans edges N+17..N+20.
      repeat (17) step();
      total++; if (a_tx !== 1'b1 || a_busy !== 1'b1) begin bad++; $display("FAIL rstf_bit3 tx=%b busy=%b want tx=1 busy=1", a_tx, a_busy); end
      #1 rst = 1'b1;
      #1;
      total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL rstf_tx got=%b want=1", a_tx); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rstf_busy got=%b want=0", a_busy); end
      total++; if (a_count !== 5'd0) begin bad++; $display("FAIL rstf_count got=%0d want=0", a_count); end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         total++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL rstf_quiet cyc=%0d tx=%b busy=%b want tx=1 busy=0", i, a_tx, a_busy); end
      end
      $display("reset_mid_frame: abort and silence checked");
   endtask

`ifdef RV_UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] bytes [2];
      logic       want_par [2];
      bytes[0] = 8'h07; want_par[0] = 1'b1;
      bytes[1] = 8'h03; want_par[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a_valid = 1'b1;
         a_data  = bytes[k];
         step();
         a_valid = 1'b0;
         for (int i = 0; i < 44; i++) begin
            step();
            if (i/4 == 9) begin
               total++; if (a_tx !== want_par[k]) begin bad++; $display("FAIL parity_bit byte=%h cyc=%0d got=%b want=%b", bytes[k], i, a_tx, want_par[k]); end
            end else begin
               total++; if (a_tx !== exp_bit(bytes[k], i/4)) begin bad++; $display("FAIL parity_tx byte=%h cyc=%0d got=%b want=%b", bytes[k], i, a_tx, exp_bit(bytes[k], i/4)); end
            end
            total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL parity_busy cyc=%0d got=%b want=1", i, a_busy); end
         end
         step();
         total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL parity_len byte=%h busy=%b want=0", bytes[k], a_busy); end
         $display("parity: byte 0x%h 44-cycle frame checked", bytes[k]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid_operation();
      test_reset_mid_frame();
`ifdef RV_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
